ami_port_merge: RTL and testbench

- Sits directly downstream of the BlockBuffer's two memory ports (rd port 0, wr port 1) in the dnnweaver AMI top.
- Merges the two AMI request streams onto a single AMI memory channel using round-robin arbitration.
- Routes read responses from that channel back to the issuing port, in issue order.
- Lets the accelerator run on platforms that expose only one AMI port per application.

---
 rtl/ami_port_merge_if.sv | 55 +++++
 rtl/ami_port_merge.sv | 142 ++++++++++++++
 tb/tb_ami_port_merge.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ami_port_merge_if.sv
// ============================================================================
// Module      : ami_port_merge_if
// Description : AMI request/response bundle between the two BlockBuffer ports,
//               the port merger and the single shared memory channel.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef AMI_REQUEST_BUS_WIDTH
`define AMI_REQUEST_BUS_WIDTH 98
`endif
`ifndef AMIRequest_valid
`define AMIRequest_valid 97
`endif
`ifndef AMIRequest_isWrite
`define AMIRequest_isWrite 96
`endif
`ifndef AMI_RESPONSE_BUS_WIDTH
`define AMI_RESPONSE_BUS_WIDTH 65
`endif
`ifndef AMIResponse_valid
`define AMIResponse_valid 64
`endif

interface ami_port_merge_if #(
    parameter int REQ_W  = `AMI_REQUEST_BUS_WIDTH,
    parameter int RESP_W = `AMI_RESPONSE_BUS_WIDTH
);
    logic [REQ_W-1:0]  req0;
    logic              req0_grant;
    logic [REQ_W-1:0]  req1;
    logic              req1_grant;
    logic [REQ_W-1:0]  mem_req;
    logic              mem_req_grant;
    logic [RESP_W-1:0] mem_resp;
    logic              mem_resp_grant;
    logic [RESP_W-1:0] resp0;
    logic              resp0_grant;
    logic [RESP_W-1:0] resp1;
    logic              resp1_grant;

    // Requesters / memory side (drives requests, memory grant and responses)
    modport master (
        output req0, req1, mem_req_grant, mem_resp, resp0_grant, resp1_grant,
        input  req0_grant, req1_grant, mem_req, mem_resp_grant, resp0, resp1
    );

    // Merger side
    modport slave (
        input  req0, req1, mem_req_grant, mem_resp, resp0_grant, resp1_grant,
        output req0_grant, req1_grant, mem_req, mem_resp_grant, resp0, resp1
    );
endinterface

`default_nettype wire

// File: rtl/ami_port_merge.sv
// ============================================================================
// Module      : ami_port_merge
// Description : Round-robin merge of two AMI request ports onto one memory
//               channel, with in-order routing of read responses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ami_port_merge #(
    parameter int REQ_W       = `AMI_REQUEST_BUS_WIDTH,
    parameter int RESP_W      = `AMI_RESPONSE_BUS_WIDTH,
    parameter int ROUTE_DEPTH = 16,
    parameter int ROUTE_AW    = 4
) (
    input  wire logic                clk,
    input  wire logic                reset,
    ami_port_merge_if.slave          bus,
    output logic [ROUTE_AW:0]        outstanding,
    output logic                     orphan_resp
);

    localparam logic [ROUTE_AW:0] c_full = (ROUTE_AW+1)'(ROUTE_DEPTH);

    logic [ROUTE_AW:0]   r_count;
    logic [ROUTE_AW-1:0] r_rd_ptr;
    logic [ROUTE_AW-1:0] r_wr_ptr;
    logic                r_rr;
    logic                r_orphan;
    logic                r_route [ROUTE_DEPTH];

    logic              w_full;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_any;
    logic              w_sel;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_head;
    logic              w_resp_valid;
    logic              w_orphan_hit;
    logic              w_mem_resp_grant;
    logic [REQ_W-1:0]  w_mem_req;
    logic [RESP_W-1:0] w_resp0;
    logic [RESP_W-1:0] w_resp1;

    // ------------------------------------------------------------------
    // Request arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_full    = (r_count == c_full);
        w_elig0   = bus.req0[`AMIRequest_valid] & (bus.req0[`AMIRequest_isWrite] | ~w_full);
        w_elig1   = bus.req1[`AMIRequest_valid] & (bus.req1[`AMIRequest_isWrite] | ~w_full);
        // Outputs during reset follow the zeroed state, so nothing is offered.
        w_any     = (w_elig0 | w_elig1) & ~reset;
        w_sel     = (w_elig0 & w_elig1) ? r_rr : w_elig1;
        w_mem_req = '0;
        if (w_any) begin
            w_mem_req = w_sel ? bus.req1 : bus.req0;
        end
        w_accept = w_any & bus.mem_req_grant;
        w_push   = w_accept & ~w_mem_req[`AMIRequest_isWrite];
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.req0_grant = w_accept & ~w_sel;
    assign bus.req1_grant = w_accept &  w_sel;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        w_resp_valid     = bus.mem_resp[`AMIResponse_valid];
        w_head           = r_route[r_rd_ptr];
        w_resp0          = '0;
        w_resp1          = '0;
        w_mem_resp_grant = 1'b0;
        w_orphan_hit     = 1'b0;
        if (r_count != '0) begin
            if (w_head) begin
                w_resp1          = bus.mem_resp;
                w_mem_resp_grant = bus.resp1_grant;
            end else begin
                w_resp0          = bus.mem_resp;
                w_mem_resp_grant = bus.resp0_grant;
            end
        end else begin
            // No read to match: swallow the response and remember it happened.
            w_mem_resp_grant = w_resp_valid & ~reset;
            w_orphan_hit     = w_resp_valid;
        end
        w_pop = w_resp_valid & w_mem_resp_grant & (r_count != '0);
    end

    assign bus.resp0          = w_resp0;
    assign bus.resp1          = w_resp1;
    assign bus.mem_resp_grant = w_mem_resp_grant;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_rr     <= 1'b0;
            r_orphan <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr <= ~w_sel;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_orphan_hit) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // Route storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_route[r_wr_ptr] <= w_sel;
        end
    end

    assign outstanding = r_count;
    assign orphan_resp = r_orphan;

endmodule

`default_nettype wire

// File: tb/tb_ami_port_merge.sv
// ============================================================================
// Module      : tb_ami_port_merge
// Description : Directed and randomized self-checking bench for ami_port_merge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ami_port_merge;

    localparam int RW = `AMI_REQUEST_BUS_WIDTH;
    localparam int SW = `AMI_RESPONSE_BUS_WIDTH;
    localparam int QV = `AMIRequest_valid;
    localparam int QW = `AMIRequest_isWrite;
    localparam int SV = `AMIResponse_valid;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] outstanding;
    logic       orphan_resp;
    int         errors = 0;
    int         checks = 0;

    ami_port_merge_if #(.REQ_W(RW), .RESP_W(SW)) bus ();

    ami_port_merge #(.REQ_W(RW), .RESP_W(SW), .ROUTE_DEPTH(DEPTH), .ROUTE_AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .outstanding (outstanding),
        .orphan_resp (orphan_resp)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of issuing port ids plus fairness/orphan state
    bit        q_ids[$];
    bit        m_rr;
    bit        m_orphan;
    bit        m_sel, m_accept, m_push, m_pop, m_orph_ev;
    logic [RW-1:0] exp_mem_req;
    logic          exp_g0, exp_g1, exp_mrg;
    logic [SW-1:0] exp_r0, exp_r1;

    function automatic logic [RW-1:0] mk_req(input bit v, input bit w);
        logic [RW-1:0] r;
        r        = '0;
        r[63:0]  = {$urandom, $urandom};
        r[95:64] = $urandom;
        r[QV]    = v;
        r[QW]    = w;
        return r;
    endfunction

    function automatic logic [SW-1:0] mk_resp(input bit v);
        logic [SW-1:0] r;
        r       = '0;
        r[63:0] = {$urandom, $urandom};
        r[SV]   = v;
        return r;
    endfunction

    task automatic set_idle();
        bus.req0          = '0;
        bus.req1          = '0;
        bus.mem_req_grant = 1'b0;
        bus.mem_resp      = '0;
        bus.resp0_grant   = 1'b0;
        bus.resp1_grant   = 1'b0;
    endtask

    task automatic model_eval();
        bit e0, e1, full, any, rv;
        full = (q_ids.size() == DEPTH);
        e0 = bus.req0[QV] && (bus.req0[QW] || !full);
        e1 = bus.req1[QV] && (bus.req1[QW] || !full);
        any = e0 || e1;
        m_sel = (e0 && e1) ? m_rr : e1;
        exp_mem_req = !any ? '0 : (m_sel ? bus.req1 : bus.req0);
        m_accept = any && bus.mem_req_grant;
        m_push   = m_accept && !exp_mem_req[QW];
        exp_g0   = m_accept && !m_sel;
        exp_g1   = m_accept && m_sel;
        rv = bus.mem_resp[SV];
        m_orph_ev = 1'b0;
        if (q_ids.size() > 0) begin
            exp_r0  = q_ids[0] ? '0 : bus.mem_resp;
            exp_r1  = q_ids[0] ? bus.mem_resp : '0;
            exp_mrg = q_ids[0] ? bus.resp1_grant : bus.resp0_grant;
            m_pop   = rv && exp_mrg;
        end else begin
            exp_r0 = '0;
            exp_r1 = '0;
            exp_mrg = rv;
            m_pop = 1'b0;
            m_orph_ev = rv;
        end
    endtask

    // Advance one clock: model follows the transfers seen in this cycle.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (m_pop) void'(q_ids.pop_front());
        if (m_push) q_ids.push_back(m_sel);
        if (m_accept) m_rr = !m_sel;
        if (m_orph_ev) m_orphan = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        reset = 1'b0;
        q_ids.delete();
        m_rr = 1'b0;
        m_orphan = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0 = mk_req(1, 0);
        bus.req1 = mk_req(1, 1);
        bus.mem_req_grant = 1'b1;
        bus.mem_resp = mk_resp(1);
        bus.resp0_grant = 1'b1;
        bus.resp1_grant = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.mem_req !== '0) begin errors++; $display("FAIL rst_mem_req got=%h exp=0", bus.mem_req); end
        checks++; if ({bus.req0_grant, bus.req1_grant} !== 2'b00) begin errors++; $display("FAIL rst_grants got=%b exp=00", {bus.req0_grant, bus.req1_grant}); end
        checks++; if (bus.mem_resp_grant !== 1'b0) begin errors++; $display("FAIL rst_mem_resp_grant got=%b exp=0", bus.mem_resp_grant); end
        checks++; if ({bus.resp0[SV], bus.resp1[SV]} !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got=%b exp=00", {bus.resp0[SV], bus.resp1[SV]}); end
        checks++; if (outstanding !== 5'd0 || orphan_resp !== 1'b0) begin errors++; $display("FAIL rst_state got=%0d/%b exp=0/0", outstanding, orphan_resp); end
        apply_reset();
    endtask

    task automatic test_alternate();
        int n0 = 0, n1 = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req0 = mk_req(1, 0);
            bus.req1 = mk_req(1, 0);
            bus.mem_req_grant = 1'b1;
            #1;
            checks++;
            if (bus.req0_grant !== (i % 2 == 0) || bus.req1_grant !== (i % 2 == 1)) begin
                errors++; $display("FAIL alt_grant[%0d] got=%b%b exp=%b%b", i, bus.req0_grant, bus.req1_grant, i % 2 == 0, i % 2 == 1);
            end
            checks++;
            if (bus.mem_req !== ((i % 2 == 1) ? bus.req1 : bus.req0)) begin
                errors++; $display("FAIL alt_mem_req[%0d] got=%h", i, bus.mem_req);
            end
            n0 += int'(bus.req0_grant);
            n1 += int'(bus.req1_grant);
            tick();
        end
        set_idle();
        checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL alt_counts got=%0d,%0d exp=4,4", n0, n1); end
        checks++; if (outstanding !== 5'd8) begin errors++; $display("FAIL alt_outstanding got=%0d exp=8", outstanding); end
    endtask

    task automatic test_stall();
        apply_reset();
        bus.req0 = mk_req(1, 0);
        bus.req1 = mk_req(1, 0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_req_grant = (i == 3);
            #1;
            checks++; if (bus.mem_req !== bus.req0) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, bus.mem_req, bus.req0); end
            checks++; if (bus.req0_grant !== (i == 3) || bus.req1_grant !== 1'b0) begin errors++; $display("FAIL stall_grant[%0d] got=%b%b", i, bus.req0_grant, bus.req1_grant); end
            tick();
        end
        bus.mem_req_grant = 1'b0;
        #1;
        checks++; if (bus.mem_req !== bus.req1) begin errors++; $display("FAIL stall_next got=%h exp=%h", bus.mem_req, bus.req1); end
        set_idle();
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.req0 = mk_req(1, 0);
            bus.mem_req_grant = 1'b1;
            tick();
        end
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL full_fill got=%0d exp=16", outstanding); end
        bus.req0 = mk_req(1, 0);
        bus.req1 = mk_req(1, 1);
        #1;
        checks++; if (bus.req0_grant !== 1'b0 || bus.req1_grant !== 1'b1) begin errors++; $display("FAIL full_grants got=%b%b exp=01", bus.req0_grant, bus.req1_grant); end
        checks++; if (bus.mem_req !== bus.req1) begin errors++; $display("FAIL full_mem_req got=%h exp=%h", bus.mem_req, bus.req1); end
        tick();
        set_idle();
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL full_hold got=%0d exp=16", outstanding); end
    endtask

    task automatic test_routing();
        logic [SW-1:0] a, b, c;
        apply_reset();
        bus.mem_req_grant = 1'b1;
        bus.req1 = mk_req(1, 0); tick(); bus.req1 = '0;
        bus.req0 = mk_req(1, 0); tick();
        bus.req0 = mk_req(1, 0); tick();
        set_idle();
        checks++; if (outstanding !== 5'd3) begin errors++; $display("FAIL route_issue got=%0d exp=3", outstanding); end
        a = mk_resp(1); b = mk_resp(1); c = mk_resp(1);
        bus.mem_resp = a; bus.resp1_grant = 1'b1;
        #1;
        checks++; if (bus.resp1 !== a || bus.resp0 !== '0 || bus.mem_resp_grant !== 1'b1) begin
            errors++; $display("FAIL route_a got r1=%h r0=%h g=%b exp r1=%h", bus.resp1, bus.resp0, bus.mem_resp_grant, a);
        end
        tick();
        bus.mem_resp = b; bus.resp1_grant = 1'b0; bus.resp0_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.resp0 !== b || bus.mem_resp_grant !== 1'b0) begin
                errors++; $display("FAIL route_b_hold[%0d] got r0=%h g=%b exp r0=%h g=0", i, bus.resp0, bus.mem_resp_grant, b);
            end
            tick();
            checks++; if (outstanding !== 5'd2) begin errors++; $display("FAIL route_b_cnt[%0d] got=%0d exp=2", i, outstanding); end
        end
        bus.resp0_grant = 1'b1;
        tick();
        checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL route_b_pop got=%0d exp=1", outstanding); end
        bus.mem_resp = c;
        #1;
        checks++; if (bus.resp0 !== c || bus.resp1 !== '0) begin errors++; $display("FAIL route_c got r0=%h r1=%h exp r0=%h", bus.resp0, bus.resp1, c); end
        tick();
        set_idle();
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL route_drain got=%0d exp=0", outstanding); end
    endtask

    task automatic test_orphan();
        bus.mem_resp = mk_resp(1);
        #1;
        checks++; if (bus.mem_resp_grant !== 1'b1 || bus.resp0[SV] !== 1'b0 || bus.resp1[SV] !== 1'b0) begin
            errors++; $display("FAIL orphan_consume got g=%b v0=%b v1=%b exp 1/0/0", bus.mem_resp_grant, bus.resp0[SV], bus.resp1[SV]);
        end
        tick();
        set_idle();
        checks++; if (orphan_resp !== 1'b1) begin errors++; $display("FAIL orphan_set got=%b exp=1", orphan_resp); end
        repeat (3) tick();
        checks++; if (orphan_resp !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b exp=1", orphan_resp); end
    endtask

    task automatic test_async_reset();
        bus.mem_req_grant = 1'b1;
        repeat (5) begin bus.req0 = mk_req(1, 0); tick(); end
        set_idle();
        checks++; if (outstanding !== 5'd5) begin errors++; $display("FAIL areset_pre got=%0d exp=5", outstanding); end
        #2 reset = 1'b1;
        #1;
        checks++; if (outstanding !== 5'd0 || orphan_resp !== 1'b0) begin
            errors++; $display("FAIL areset_now got=%0d/%b exp=0/0", outstanding, orphan_resp);
        end
        @(negedge clk);
        reset = 1'b0;
        q_ids.delete(); m_rr = 1'b0; m_orphan = 1'b0;
        bus.req0 = mk_req(1, 0);
        bus.req1 = mk_req(1, 0);
        #1;
        checks++; if (bus.mem_req !== bus.req0) begin errors++; $display("FAIL areset_ptr got=%h exp=%h", bus.mem_req, bus.req0); end
        set_idle();
        bus.mem_resp = mk_resp(1);
        tick();
        set_idle();
        checks++; if (orphan_resp !== 1'b1) begin errors++; $display("FAIL areset_orphan got=%b exp=1", orphan_resp); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            bus.req0 = mk_req($urandom_range(3) != 0, $urandom_range(2) == 0);
            bus.req1 = mk_req($urandom_range(3) != 0, $urandom_range(2) == 0);
            bus.mem_req_grant = ($urandom_range(3) != 0);
            bus.mem_resp = mk_resp($urandom_range(2) == 0);
            bus.resp0_grant = ($urandom_range(3) != 0);
            bus.resp1_grant = ($urandom_range(3) != 0);
            #1;
            model_eval();
            checks++; if (bus.mem_req !== exp_mem_req) begin errors++; $display("FAIL rnd_mem_req[%0d] got=%h exp=%h", i, bus.mem_req, exp_mem_req); end
            checks++; if ({bus.req0_grant, bus.req1_grant} !== {exp_g0, exp_g1}) begin errors++; $display("FAIL rnd_grants[%0d] got=%b%b exp=%b%b", i, bus.req0_grant, bus.req1_grant, exp_g0, exp_g1); end
            checks++; if (bus.mem_resp_grant !== exp_mrg) begin errors++; $display("FAIL rnd_mem_resp_grant[%0d] got=%b exp=%b", i, bus.mem_resp_grant, exp_mrg); end
            checks++; if (bus.resp0 !== exp_r0 || bus.resp1 !== exp_r1) begin errors++; $display("FAIL rnd_resp[%0d] got=%h/%h exp=%h/%h", i, bus.resp0, bus.resp1, exp_r0, exp_r1); end
            checks++; if (outstanding !== 5'(q_ids.size())) begin errors++; $display("FAIL rnd_outstanding[%0d] got=%0d exp=%0d", i, outstanding, q_ids.size()); end
            checks++; if (orphan_resp !== m_orphan) begin errors++; $display("FAIL rnd_orphan[%0d] got=%b exp=%b", i, orphan_resp, m_orphan); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        test_reset();
        test_alternate();
        test_stall();
        test_full();
        test_routing();
        test_orphan();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
